// File: rtl/traffic_density_encoder.sv
// Per-direction vehicle density encoder: sync + debounce, windowed saturating count, 2-bit code.
// Define TRAFFIC_HYST_EN to hold a downgraded code for one extra window (max of current/previous).
module traffic_density_encoder #(
    parameter int WINDOW_CYCLES = 100,
    parameter int CNT_W         = 8,
    parameter int LOW_MAX       = 3,
    parameter int HIGH_MIN      = 8,
    parameter int DEBOUNCE      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       veh_NS,
    input  logic       veh_EW,
    output logic [1:0] traffic_NS,
    output logic [1:0] traffic_EW,
    output logic       level_valid
);

    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic [1:0] {
        DENS_LOW  = 2'b00,
        DENS_MOD  = 2'b01,
        DENS_HIGH = 2'b10
    } density_t;

    // Index 0 = North-South, index 1 = East-West
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [1:0]       filt_q;
    logic [1:0]       veh_edge;
    logic [DB_W-1:0]  db_cnt  [2];
    logic [CNT_W-1:0] cnt     [2];
    logic [CNT_W-1:0] cnt_inc [2];
    density_t         raw_code [2];
    density_t         out_code [2];
    density_t         code_q   [2];
    logic [WIN_W-1:0] win_cnt;
    logic             terminal;

    assign raw      = {veh_EW, veh_NS};
    assign terminal = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign veh_edge = filt & ~filt_q;

    function automatic density_t classify(input logic [CNT_W-1:0] c);
        if (32'(c) <= 32'(LOW_MAX)) begin
            return DENS_LOW;
        end else if (32'(c) >= 32'(HIGH_MIN)) begin
            return DENS_HIGH;
        end else begin
            return DENS_MOD;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_q <= '0;
            for (int unsigned d = 0; d < 2; d++) begin
                db_cnt[d] <= '0;
            end
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_q <= filt;
            // Filtered level flips only once the synchronised level has disagreed for DEBOUNCE cycles
            for (int unsigned d = 0; d < 2; d++) begin
                if (sync2[d] != filt[d]) begin
                    if (db_cnt[d] == DB_W'(DEBOUNCE - 1)) begin
                        filt[d]   <= sync2[d];
                        db_cnt[d] <= '0;
                    end else begin
                        db_cnt[d] <= db_cnt[d] + DB_W'(1);
                    end
                end else begin
                    db_cnt[d] <= '0;
                end
            end
        end
    end

    // Count including this cycle's edge, so a terminal-cycle vehicle is still classified
    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            cnt_inc[d] = cnt[d];
            if (veh_edge[d] && (cnt[d] != '1)) begin
                cnt_inc[d] = cnt[d] + CNT_W'(1);
            end
            raw_code[d] = classify(cnt_inc[d]);
        end
    end

`ifdef TRAFFIC_HYST_EN
    density_t prev_q [2];

    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            out_code[d] = (raw_code[d] > prev_q[d]) ? raw_code[d] : prev_q[d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned d = 0; d < 2; d++) begin
                prev_q[d] <= DENS_LOW;
            end
        end else if (terminal) begin
            for (int unsigned d = 0; d < 2; d++) begin
                prev_q[d] <= raw_code[d];
            end
        end
    end
`else
    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            out_code[d] = raw_code[d];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            level_valid <= 1'b0;
            for (int unsigned d = 0; d < 2; d++) begin
                cnt[d]    <= '0;
                code_q[d] <= DENS_LOW;
            end
        end else begin
            level_valid <= terminal;
            if (terminal) begin
                win_cnt <= '0;
                for (int unsigned d = 0; d < 2; d++) begin
                    cnt[d]    <= '0;
                    code_q[d] <= out_code[d];
                end
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                for (int unsigned d = 0; d < 2; d++) begin
                    cnt[d] <= cnt_inc[d];
                end
            end
        end
    end

    assign traffic_NS = code_q[0];
    assign traffic_EW = code_q[1];

endmodule
